// File: rtl/argmax_8_16_pkg.sv
// Shared definitions for the classifier argmax stage and the layer blocks
// that feed it: vector geometry and the collector FSM state type.
package argmax_8_16_pkg;

    localparam int M    = 8;              // words per input vector
    localparam int T    = 16;             // word width, two's complement
    localparam int logM = $clog2(M + 1);  // word counter / index width

    typedef enum logic {
        COLLECT,
        OUTPUT
    } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare/select: given the running best and a new
// candidate, produce the next best value and index. Strict greater-than,
// so ties keep the earlier (lower) index. 'first' forces the candidate in.
module argmax_cmp
    import argmax_8_16_pkg::*;
(
    input  logic                   first,
    input  logic signed [T-1:0]    best_val,
    input  logic        [logM-1:0] best_idx,
    input  logic signed [T-1:0]    cand_val,
    input  logic        [logM-1:0] cand_idx,
    output logic signed [T-1:0]    next_val,
    output logic        [logM-1:0] next_idx
);

    logic take;

    // Select candidate when it opens a vector or strictly beats the best
    always_comb begin
        take     = first || (cand_val > best_val);
        next_val = take ? cand_val : best_val;
        next_idx = take ? cand_idx : best_idx;
    end

endmodule

// File: rtl/argmax_8_16.sv
// Argmax classifier stage: collects M signed words per vector over
// valid/ready and emits the index and value of the largest word.
// Word input is stalled while a result waits for the downstream consumer.
module argmax_8_16
    import argmax_8_16_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [T-1:0]    data_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic        [logM-1:0] idx_out,
    output logic signed [T-1:0]    max_out
);

    localparam logic [logM-1:0] LAST_IDX = logM'(M - 1);

    argmax_state_t             state;
    logic          [logM-1:0]  count;
    logic signed   [T-1:0]     best_val;
    logic          [logM-1:0]  best_idx;
    logic signed   [T-1:0]     next_val;
    logic          [logM-1:0]  next_idx;
    logic                      word_xfer;

    // Only the ready output is combinational; held low while in reset
    assign s_ready   = (state == COLLECT) && reset;
    assign word_xfer = s_valid && s_ready;

    argmax_cmp u_cmp (
        .first    (count == '0),
        .best_val (best_val),
        .best_idx (best_idx),
        .cand_val (data_in),
        .cand_idx (count),
        .next_val (next_val),
        .next_idx (next_idx)
    );

    // Collector FSM: running best, word counter and registered result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= COLLECT;
            count    <= '0;
            best_val <= '0;
            best_idx <= '0;
            m_valid  <= 1'b0;
            idx_out  <= '0;
            max_out  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (word_xfer) begin
                        best_val <= next_val;
                        best_idx <= next_idx;
                        if (count == LAST_IDX) begin
                            idx_out <= next_idx;
                            max_out <= next_val;
                            m_valid <= 1'b1;
                            count   <= '0;
                            state   <= OUTPUT;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
